mac_threshold_unit: RTL and testbench
=====================================

MAC_THRESHOLD_UNIT -- requirements
Module: mac_threshold_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, default 8, SHALL set the signed operand width.
REQ-003 Parameter ACC_W, default 20, SHALL set the signed accumulator and threshold width.
REQ-004 Parameter N_PAIRS, default 64, SHALL set the number of operand pairs per inference.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 rst_mem  in  1  synchronous clear of accumulator, pipeline and FSM, from the control unit.
REQ-008 mul_mem_en  in  1  the operand pair on data_a/data_b is valid this cycle.
REQ-009 ac_mem_en  in  1  the sampled product is to be accumulated.
REQ-010 rd_data_ptr  in  6  index of the current pair.
REQ-011 data_a, data_b  in  DATA_W  signed operands read from memory.
REQ-012 threshold  in  ACC_W  signed threshold value.
REQ-013 threshold_ready  in  1  latch threshold this cycle.
REQ-014 out_ack  in  1  consumer has taken the result.
REQ-015 acc_out  out  ACC_W  final signed sum.
REQ-016 neuron_out  out  1  the neuron fires: acc_out >= latched threshold.
REQ-017 out_valid  out  1  acc_out and neuron_out are valid.
REQ-018 ovf  out  1  sticky saturation flag for the current inference.
REQ-019 busy  out  1  the FSM is not in IDLE.

Function
REQ-020 The FSM SHALL have the states IDLE, ACCUM, DRAIN and DONE.
REQ-021 IDLE->ACCUM SHALL occur on the first cycle with mul_mem_en=1; that pair SHALL be sampled.
REQ-022 Stage 1: when mul_mem_en=1, the block SHALL register the full-width signed product data_a*data_b (2*DATA_W bits), set p_vld, and register ac_mem_en as p_acc.
REQ-023 Stage 2: when p_vld & p_acc, the block SHALL sign-extend the product to ACC_W and add it to the accumulator.
REQ-024 A cycle with mul_mem_en=0 SHALL be a bubble: p_vld=0 and the accumulator is unchanged.
REQ-025 ACCUM->DRAIN SHALL occur when the pair with mul_mem_en=1 and rd_data_ptr==N_PAIRS-1 is sampled; later repeats of that pointer SHALL be ignored.
REQ-026 DRAIN SHALL last exactly 2 cycles.
REQ-027 DRAIN->DONE: out_valid SHALL rise 3 cycles after the edge that sampled the last pair.
REQ-028 neuron_out SHALL be registered at DONE entry as signed compare acc >= thr_q.
REQ-029 In DONE, out_valid, acc_out, neuron_out and ovf SHALL hold stable until out_ack=1.
REQ-030 DONE->IDLE SHALL occur on out_ack=1; out_valid SHALL drop the next cycle; the accumulator and ovf SHALL clear on IDLE entry.
REQ-031 thr_q SHALL load on threshold_ready=1 in any state except DONE; in DONE the update SHALL be deferred by one cycle after exit.
REQ-032 rst_mem=1 in any state SHALL clear the accumulator, p_vld, ovf and out_valid and force IDLE; it SHALL take priority over mul_mem_en and out_ack.
REQ-033 mul_mem_en in DONE SHALL be ignored.
REQ-034 busy SHALL be 1 in ACCUM, DRAIN and DONE.

Reset
REQ-035 rst SHALL force IDLE and set acc, thr_q, p_vld, p_acc, ovf, out_valid, neuron_out and acc_out to 0.
REQ-036 Deassertion of rst SHALL be synchronised externally; the block SHALL add no reset synchroniser.

Configuration
REQ-037 With MAC_SATURATE_EN defined, an add that overflows SHALL clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and set ovf.
REQ-038 Without MAC_SATURATE_EN, the add SHALL wrap in two's complement and ovf SHALL be tied to 0.

Structure
REQ-039 Package neuron_pkg SHALL hold DATA_W, ACC_W, N_PAIRS defaults and the mac_state_t enum.
REQ-040 The saturating/wrapping adder SHALL be the sub-module sat_add; all other logic stays in mac_threshold_unit.

Verification
REQ-041 64 pairs of a=1, b=1 with threshold 64 -> acc_out=64, neuron_out=1, out_valid 3 cycles after the last sample.
REQ-042 The same data with threshold 65 -> acc_out=64, neuron_out=0.
REQ-043 64 pairs of a=-128, b=-128 -> with MAC_SATURATE_EN: acc_out=524287, ovf=1; without it: acc_out=0 (1048576 mod 2^20), ovf=0.
REQ-044 rst_mem pulsed at pair 30 -> next cycle acc=0, busy=0, no out_valid.
REQ-045 out_ack withheld 10 cycles -> outputs stable throughout; ack -> IDLE, out_valid=0 the next cycle.
REQ-046 64 pairs a=2, b=3 with random mul_mem_en bubbles -> acc_out=384, the same as the gapless run.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared defaults and FSM encoding for the MAC/threshold neuron datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package neuron_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int ACC_W_DEF   = 20;
    localparam int N_PAIRS_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mac_state_t;

endpackage

// File: rtl/sat_add.sv
// Signed W-bit adder; saturating with ovf flag when MAC_SATURATE_EN is defined, else wrapping.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (signed operands), sum (result), ovf (add overflowed and was clamped).
// Build option: MAC_SATURATE_EN selects clamping; without it the add wraps and ovf is 0.
module sat_add #(
    parameter int W = 20
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W-1:0] raw_sum;

    assign raw_sum = a + b;

`ifdef MAC_SATURATE_EN
    logic over;

    // Overflow is only possible when both operands share a sign and the
    // result's sign differs from it.
    assign over = (a[W-1] == b[W-1]) && (raw_sum[W-1] != a[W-1]);

    always_comb begin
        sum = raw_sum;
        if (over) begin
            sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    assign ovf = over;
`else
    assign sum = raw_sum;
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/mac_threshold_unit.sv
// Two-stage signed multiply-accumulate over N_PAIRS operand pairs, then a compare against a latched threshold.
// Latency: out_valid rises in the third cycle counted from the cycle the last pair is presented (2 drain cycles).
// Backpressure: result held in DONE until out_ack; operand pairs arriving in DRAIN/DONE are ignored.
// Ports: clk, rst (async, active-high), rst_mem (sync clear), mul_mem_en/ac_mem_en/rd_data_ptr/data_a/data_b
//        (operand stream), threshold/threshold_ready (threshold load), out_ack (consumer handshake),
//        acc_out/neuron_out/out_valid/ovf (result), busy (FSM not idle).
// Build option: MAC_SATURATE_EN enables saturating accumulation and the sticky ovf flag (inside sat_add).
module mac_threshold_unit
    import neuron_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int N_PAIRS = N_PAIRS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_mem,
    input  logic              mul_mem_en,
    input  logic              ac_mem_en,
    input  logic [5:0]        rd_data_ptr,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [ACC_W-1:0]  threshold,
    input  logic              threshold_ready,
    input  logic              out_ack,
    output logic [ACC_W-1:0]  acc_out,
    output logic              neuron_out,
    output logic              out_valid,
    output logic              ovf,
    output logic              busy
);

    localparam logic [5:0] PTR_LAST = 6'(N_PAIRS - 1);

    mac_state_t state;
    logic       drain_cnt;

    // Stage 1 registers
    logic [2*DATA_W-1:0] p_dat;
    logic                p_vld;
    logic                p_acc;

    // Stage 2 / threshold registers
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] thr_q;
    logic [ACC_W-1:0] thr_pend;
    logic             thr_pend_vld;

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    p_ext;
    logic [ACC_W-1:0]    add_sum;
    logic                add_ovf;
    logic                sample;
    logic                last_pair;
    logic                add_en;

    // Low 2*DATA_W bits of the product of sign-extended operands equal the
    // full signed product, so an unsigned multiply is sufficient here.
    assign a_ext = {{DATA_W{data_a[DATA_W-1]}}, data_a};
    assign b_ext = {{DATA_W{data_b[DATA_W-1]}}, data_b};
    assign prod  = a_ext * b_ext;
    assign p_ext = {{(ACC_W-2*DATA_W){p_dat[2*DATA_W-1]}}, p_dat};

    // Pairs are only taken before the last pointer has been seen; anything
    // presented in DRAIN or DONE would corrupt the finished sum.
    assign sample    = mul_mem_en && ((state == ST_IDLE) || (state == ST_ACCUM));
    assign last_pair = sample && (rd_data_ptr == PTR_LAST);
    assign add_en    = p_vld && p_acc;
    assign busy      = (state != ST_IDLE);

    sat_add #(.W(ACC_W)) u_sat_add (
        .a   (acc),
        .b   (p_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            drain_cnt    <= 1'b0;
            p_dat        <= '0;
            p_vld        <= 1'b0;
            p_acc        <= 1'b0;
            acc          <= '0;
            thr_q        <= '0;
            thr_pend     <= '0;
            thr_pend_vld <= 1'b0;
            ovf          <= 1'b0;
            out_valid    <= 1'b0;
            neuron_out   <= 1'b0;
            acc_out      <= '0;
        end else begin
            // A threshold arriving while a result is on display is parked and
            // applied on the cycle after DONE is left, so the consumer never
            // sees the compare basis change under it.
            if (state == ST_DONE) begin
                if (threshold_ready) begin
                    thr_pend     <= threshold;
                    thr_pend_vld <= 1'b1;
                end
            end else if (threshold_ready) begin
                thr_q        <= threshold;
                thr_pend_vld <= 1'b0;
            end else if (thr_pend_vld) begin
                thr_q        <= thr_pend;
                thr_pend_vld <= 1'b0;
            end

            if (rst_mem) begin
                state     <= ST_IDLE;
                drain_cnt <= 1'b0;
                p_vld     <= 1'b0;
                p_acc     <= 1'b0;
                acc       <= '0;
                ovf       <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                p_vld <= sample;
                p_acc <= sample && ac_mem_en;
                if (sample) begin
                    p_dat <= prod;
                end

                if (add_en) begin
                    acc <= add_sum;
                    ovf <= ovf | add_ovf;
                end

                case (state)
                    ST_IDLE: begin
                        if (sample) begin
                            state     <= last_pair ? ST_DRAIN : ST_ACCUM;
                            drain_cnt <= 1'b0;
                        end
                    end
                    ST_ACCUM: begin
                        if (last_pair) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        // First drain cycle lets stage 2 absorb the last
                        // product; the second publishes the settled sum.
                        if (drain_cnt) begin
                            state      <= ST_DONE;
                            out_valid  <= 1'b1;
                            acc_out    <= acc;
                            neuron_out <= ($signed(acc) >= $signed(thr_q));
                        end else begin
                            drain_cnt <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (out_ack) begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            acc       <= '0;
                            ovf       <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mac_threshold_unit.sv
// Randomised bench for mac_threshold_unit with a sum-of-products reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mac_threshold_unit;

    localparam int DW  = 8;
    localparam int AW  = 20;
    localparam int NP  = 64;
    localparam int INF = 1 << 30;
    localparam longint MAXV = (longint'(1) << (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (AW - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rst_mem = 1'b0;
    logic          mul_mem_en = 1'b0;
    logic          ac_mem_en = 1'b0;
    logic [5:0]    rd_data_ptr = '0;
    logic [DW-1:0] data_a = '0;
    logic [DW-1:0] data_b = '0;
    logic [AW-1:0] threshold = '0;
    logic          threshold_ready = 1'b0;
    logic          out_ack = 1'b0;
    logic [AW-1:0] acc_out;
    logic          neuron_out;
    logic          out_valid;
    logic          ovf;
    logic          busy;

    mac_threshold_unit dut (
        .clk             (clk),
        .rst             (rst),
        .rst_mem         (rst_mem),
        .mul_mem_en      (mul_mem_en),
        .ac_mem_en       (ac_mem_en),
        .rd_data_ptr     (rd_data_ptr),
        .data_a          (data_a),
        .data_b          (data_b),
        .threshold       (threshold),
        .threshold_ready (threshold_ready),
        .out_ack         (out_ack),
        .acc_out         (acc_out),
        .neuron_out      (neuron_out),
        .out_valid       (out_valid),
        .ovf             (ovf),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Timeline expectations, expressed as cycle windows.
    int busy_from   = -1;
    int busy_until  = INF;
    int valid_from  = INF;
    int valid_until = INF;
    logic [AW-1:0] exp_acc = '0;
    int  exp_fire = 0;
    int  exp_ovf  = 0;
    bit  chk_en   = 1'b0;
    int  thr_m    = 0;

    int q_a[$];
    int q_b[$];
    int q_e[$];

    // Reference: sum the accumulated products in order, clamping or wrapping.
    function automatic void model_run(input int thr_v);
        longint s = 0;
        int     o = 0;
        foreach (q_a[i]) begin
            if (q_e[i] != 0) begin
                s += longint'(q_a[i] * q_b[i]);
`ifdef MAC_SATURATE_EN
                if (s > MAXV) begin
                    s = MAXV;
                    o = 1;
                end else if (s < MINV) begin
                    s = MINV;
                    o = 1;
                end
`else
                s = s & ((longint'(1) << AW) - 1);
                if (s > MAXV) s = s - (longint'(1) << AW);
`endif
            end
        end
        exp_acc  = s[AW-1:0];
        exp_fire = (s >= longint'(thr_v)) ? 1 : 0;
        exp_ovf  = o;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            int ev;
            int eb;
            ev = (cyc >= valid_from && cyc <= valid_until) ? 1 : 0;
            eb = (busy_from >= 0 && cyc > busy_from && cyc <= busy_until) ? 1 : 0;
            chk("out_valid", int'(out_valid), ev);
            chk("busy", int'(busy), eb);
            if (ev != 0) begin
                chk("acc_out", int'(acc_out), int'(exp_acc));
                chk("neuron_out", int'(neuron_out), exp_fire);
                chk("ovf", int'(ovf), exp_ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_thr(input int t);
        threshold       = t[AW-1:0];
        threshold_ready = 1'b1;
        thr_m           = t;
        tick();
        threshold_ready = 1'b0;
    endtask

    task automatic run_inf(input int mode, input int bubble_pct, input int drop_pct,
                           input int ack_delay, input bit extra_last,
                           input int thr_mid, input int thr_val,
                           input bit thr_done, input int thr_done_val,
                           input bit use_lit, input int lit_acc, input int lit_fire,
                           input int lit_ovf);
        int a;
        int b;
        int e;
        q_a.delete();
        q_b.delete();
        q_e.delete();
        for (int i = 0; i < NP; i++) begin
            while (int'($urandom_range(99)) < bubble_pct) begin
                mul_mem_en  = 1'b0;
                ac_mem_en   = 1'($urandom);
                rd_data_ptr = 6'($urandom);
                data_a      = DW'($urandom);
                data_b      = DW'($urandom);
                tick();
            end
            case (mode)
                0:       begin a = 1;    b = 1;    end
                1:       begin a = -128; b = -128; end
                2:       begin a = 2;    b = 3;    end
                default: begin
                    a = int'($urandom_range(255)) - 128;
                    b = int'($urandom_range(255)) - 128;
                end
            endcase
            e = (int'($urandom_range(99)) >= drop_pct) ? 1 : 0;
            mul_mem_en  = 1'b1;
            ac_mem_en   = (e != 0);
            rd_data_ptr = i[5:0];
            data_a      = a[DW-1:0];
            data_b      = b[DW-1:0];
            threshold_ready = 1'b0;
            if (i == thr_mid) begin
                threshold       = thr_val[AW-1:0];
                threshold_ready = 1'b1;
                thr_m           = thr_val;
            end
            q_a.push_back(a);
            q_b.push_back(b);
            q_e.push_back(e);
            if (i == 0) begin
                busy_from  = cyc;
                busy_until = INF;
            end
            if (i == NP - 1) begin
                model_run(thr_m);
                valid_from  = cyc + 3;
                valid_until = INF;
            end
            tick();
        end
        threshold_ready = 1'b0;
        // Optional repeats of the last pointer must be ignored in DRAIN/DONE.
        mul_mem_en  = extra_last;
        ac_mem_en   = 1'b1;
        rd_data_ptr = 6'(NP - 1);
        data_a      = 8'd100;
        data_b      = 8'd100;
        while (cyc < valid_from) tick();
        if (use_lit) begin
            chk("lit_acc", int'(acc_out), lit_acc);
            chk("lit_fire", int'(neuron_out), lit_fire);
            chk("lit_ovf", int'(ovf), lit_ovf);
            chk("lit_valid", int'(out_valid), 1);
        end
        for (int d = 0; d < ack_delay; d++) begin
            if (thr_done && d == 0) begin
                threshold       = thr_done_val[AW-1:0];
                threshold_ready = 1'b1;
                thr_m           = thr_done_val;
            end
            tick();
            threshold_ready = 1'b0;
        end
        mul_mem_en  = 1'b0;
        out_ack     = 1'b1;
        valid_until = cyc;
        busy_until  = cyc;
        tick();
        out_ack = 1'b0;
        chk("ack_drop", int'(out_valid), 0);
        tick();
    endtask

    task automatic rst_mem_test();
        for (int i = 0; i <= 30; i++) begin
            mul_mem_en  = 1'b1;
            ac_mem_en   = 1'b1;
            rd_data_ptr = i[5:0];
            data_a      = 8'd2;
            data_b      = 8'd3;
            if (i == 0) begin
                busy_from  = cyc;
                busy_until = INF;
            end
            if (i == 30) begin
                rst_mem    = 1'b1;
                busy_until = cyc;
            end
            tick();
        end
        rst_mem    = 1'b0;
        mul_mem_en = 1'b0;
        chk("rst_mem_busy", int'(busy), 0);
        chk("rst_mem_ovf", int'(ovf), 0);
        chk("rst_mem_valid", int'(out_valid), 0);
        repeat (4) tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_acc_out", int'(acc_out), 0);
        chk("rst_neuron_out", int'(neuron_out), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst = 1'b0;
        tick();
        chk_en = 1'b1;

        // 64 x (1*1) against thresholds 64 and 65
        load_thr(64);
        run_inf(0, 0, 0, 2, 1'b0, -1, 0, 1'b0, 0, 1'b1, 64, 1, 0);
        load_thr(65);
        run_inf(0, 0, 0, 0, 1'b0, -1, 0, 1'b0, 0, 1'b1, 64, 0, 0);

        // 64 x (-128*-128) = 2^20
        load_thr(0);
`ifdef MAC_SATURATE_EN
        run_inf(1, 0, 0, 1, 1'b0, -1, 0, 1'b0, 0, 1'b1, 524287, 1, 1);
`else
        run_inf(1, 0, 0, 1, 1'b0, -1, 0, 1'b0, 0, 1'b1, 0, 1, 0);
`endif

        // Synchronous clear mid-stream, then a clean run proves acc was cleared.
        rst_mem_test();
        run_inf(0, 0, 0, 1, 1'b0, -1, 0, 1'b0, 0, 1'b1, 64, 1, 0);

        // Long hold before ack; a threshold of 400 arrives during DONE.
        run_inf(2, 0, 0, 10, 1'b0, -1, 0, 1'b1, 400, 1'b1, 384, 1, 0);
        // Bubbled stream uses the deferred threshold: 384 < 400.
        run_inf(2, 40, 0, 1, 1'b0, -1, 0, 1'b0, 0, 1'b1, 384, 0, 0);

        // Repeats of the last pointer in DRAIN/DONE are ignored.
        load_thr(64);
        run_inf(0, 0, 0, 3, 1'b1, -1, 0, 1'b0, 0, 1'b1, 64, 1, 0);

        // Random operands, bubbles, dropped accumulates, mid-stream thresholds.
        for (int r = 0; r < 8; r++) begin
            run_inf(3, 30, 20, int'($urandom_range(5)), 1'($urandom),
                    int'($urandom_range(62)), int'($urandom_range(4000)) - 2000,
                    1'b0, 0, 1'b0, 0, 0, 0);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
